correlator_readout: RTL and testbench
=====================================

Name: correlator_readout

Overview:
- Downstream stage of the intensity correlator.
- Runs a fixed integration window, then snapshots the correlator's flat counter bus (MAX_DELAY lags × RESOLUTION bits) into a shadow register.
- Pulses a clear to the correlator counters, then streams the snapshot one lag per beat over a valid/ready interface to the host-side capture logic.
- Integration of the next frame overlaps streaming of the current one.

Parameters:
- MAX_DELAY, 501, number of lag counters on the input bus; beats per frame.
- RESOLUTION, 32, width of each counter and of m_data.
- INTEG_CYCLES, 1000000, clock cycles per integration window; must be ≥ 2.
- TIMER_WIDTH, 32, width of the integration timer; must hold INTEG_CYCLES-1.
- IDX_WIDTH, 9, width of m_index; must hold MAX_DELAY-1.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  integration timer runs while high.
- counts_in  in  RESOLUTION*MAX_DELAY  correlator counter bus; lag i at [RESOLUTION*i +: RESOLUTION].
- corr_clear  out  1  one-cycle high pulse clearing the correlator counters.
- m_data  out  RESOLUTION  current lag count.
- m_index  out  IDX_WIDTH  lag number of m_data.
- m_valid  out  1  beat valid.
- m_ready  in  1  consumer accepts beat.
- m_last  out  1  high on the final beat of a frame.
- frame_count  out  16  frames snapshotted since reset; wraps 0xFFFF→0.
- overrun  out  1  sticky: a window ended while a frame was still streaming.

Behaviour:
- Reset (reset=0, async): timer=0, state IDLE, shadow=0. All outputs 0: corr_clear, m_data, m_index, m_valid, m_last, frame_count, overrun. A reset mid-stream aborts the frame; no further beats are issued.
- Timer:
  - Increments each cycle enable=1. Holds value when enable=0 (no clear).
  - "Window end" is the cycle T with enable=1 and timer==INTEG_CYCLES-1. Timer returns to 0 at T+1.
- At window end T:
  - corr_clear=1 in cycle T+1 only, whether or not a snapshot is taken.
  - State IDLE: shadow ← counts_in sampled at edge T; frame_count+1; state STREAM. In cycle T+1: m_valid=1, m_index=0, m_data=lag 0.
  - State STREAM: the snapshot is dropped; overrun ← 1 (cleared only by reset); frame_count unchanged; the current stream continues untouched.
- State STREAM:
  - Beat k presents m_index=k and m_data=shadow lag k. m_last=(k==MAX_DELAY-1).
  - A beat transfers on m_valid & m_ready at a rising edge.
  - While m_valid=1 and m_ready=0, m_data, m_index and m_last hold stable; m_valid never drops.
  - After a transfer with k<MAX_DELAY-1, beat k+1 is presented next cycle (full throughput, one beat per cycle with m_ready held high).
  - Transfer of the last beat → IDLE next cycle; m_valid=0, m_last=0, m_index=0.
  - Minimum frame latency: window end to last beat = MAX_DELAY cycles.
- Simultaneous events: last beat transfers in cycle T of a window end → still treated as STREAM (dropped, overrun set). Snapshot requires IDLE at edge T.
- enable=0 does not stop streaming or a pending corr_clear.
- States: IDLE, STREAM (plus HEADER when optional feature on).

Optional Feature:
- CORR_READOUT_HEADER_EN defined:
  - Each frame starts with one header beat from state HEADER.
  - Header contents: m_data = {frame_count after increment, zero-extended/truncated to RESOLUTION}, m_index=0, m_last=0.
  - Lag beats then follow as above. Frame = MAX_DELAY+1 beats; minimum frame latency MAX_DELAY+1 cycles.
  - Extra 1-bit output m_header, high only on the header beat.
- Not defined: no HEADER state, no m_header port; frames are exactly MAX_DELAY beats.

Test Plan:
All scenarios use MAX_DELAY=4, RESOLUTION=8, INTEG_CYCLES=10, IDX_WIDTH=2.
- Basic frame: reset, enable=1, m_ready=1, counts_in lags={0x11,0x22,0x33,0x44} at cycle 9 → corr_clear high cycle 10 only; beats (0,0x11)…(3,0x44) in cycles 10–13; m_last in cycle 13; frame_count=1.
- Backpressure: m_ready=0 on cycles 11–13 → beat (1,0x22) held stable three cycles with m_valid=1; stream completes cycle 16; no data loss or duplication.
- Overrun: m_ready=0 from cycle 10 to 25 → at window end cycle 19, corr_clear pulses cycle 20; overrun=1; frame_count stays 1; stream still delivers the original 0x11..0x44.
- Enable pause: enable=0 cycles 3–7 → window end moves to cycle 14; corr_clear at 15; timer value frozen at 3 during pause.
- Async reset mid-stream: reset=0 during beat 2 → m_valid, frame_count, overrun drop to 0 immediately without clock edge; after release, next frame starts at index 0.
- Header (macro on): basic frame → cycle 10 beat m_header=1 with m_data=0x01; lags in cycles 11–14; m_last in cycle 14.

Source files
------------

// File: rtl/correlator_readout.sv
// Snapshots the correlator counter bus every INTEG_CYCLES and streams it one lag per beat; first beat 1 cycle after window end.
// m_valid holds while m_ready is low; windows ending mid-stream are dropped and flagged on overrun. Header beat: CORR_READOUT_HEADER_EN.
module correlator_readout #(
  parameter int MAX_DELAY    = 501,
  parameter int RESOLUTION   = 32,
  parameter int INTEG_CYCLES = 1000000,
  parameter int TIMER_WIDTH  = 32,
  parameter int IDX_WIDTH    = 9
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [RESOLUTION*MAX_DELAY-1:0] counts_in,
  output logic                            corr_clear,
  output logic [RESOLUTION-1:0]           m_data,
  output logic [IDX_WIDTH-1:0]            m_index,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic                            m_last,
`ifdef CORR_READOUT_HEADER_EN
  output logic                            m_header,
`endif
  output logic [15:0]                     frame_count,
  output logic                            overrun
);

  localparam logic [TIMER_WIDTH-1:0] T_LAST = TIMER_WIDTH'(INTEG_CYCLES - 1);
  localparam logic [IDX_WIDTH-1:0]   I_LAST = IDX_WIDTH'(MAX_DELAY - 1);

`ifdef CORR_READOUT_HEADER_EN
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, HEADER = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1} state_t;
`endif

  state_t                  state_q, state_d;
  logic [TIMER_WIDTH-1:0]  timer_q;
  logic [IDX_WIDTH-1:0]    idx_q;
  logic [RESOLUTION-1:0]   shadow [MAX_DELAY];
  logic                    win_end;
  logic                    snap;
  logic                    drop;

  assign win_end = enable && (timer_q == T_LAST);

`ifdef CORR_READOUT_HEADER_EN
  // header carries the already-incremented frame number, fitted to the data width
  logic [RESOLUTION+15:0] fc_ext;
  assign fc_ext = {{RESOLUTION{1'b0}}, frame_count};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    snap    = 1'b0;
    drop    = 1'b0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_index = '0;
    m_data  = '0;
`ifdef CORR_READOUT_HEADER_EN
    m_header = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (win_end) begin
          snap = 1'b1;
`ifdef CORR_READOUT_HEADER_EN
          state_d = HEADER;
`else
          state_d = STREAM;
`endif
        end
      end
`ifdef CORR_READOUT_HEADER_EN
      HEADER: begin
        drop     = win_end;
        m_valid  = 1'b1;
        m_header = 1'b1;
        m_data   = fc_ext[RESOLUTION-1:0];
        if (m_ready) state_d = STREAM;
      end
`endif
      STREAM: begin
        // a window closing here loses its snapshot even if this is the last beat
        drop    = win_end;
        m_valid = 1'b1;
        m_index = idx_q;
        m_data  = shadow[idx_q];
        m_last  = (idx_q == I_LAST);
        if (m_ready && idx_q == I_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q     <= '0;
      idx_q       <= '0;
      corr_clear  <= 1'b0;
      frame_count <= '0;
      overrun     <= 1'b0;
      for (int i = 0; i < MAX_DELAY; i++) shadow[i] <= '0;
    end else begin
      corr_clear <= win_end;
      if (enable) timer_q <= win_end ? '0 : timer_q + TIMER_WIDTH'(1);
      if (snap) begin
        frame_count <= frame_count + 16'd1;
        for (int i = 0; i < MAX_DELAY; i++) shadow[i] <= counts_in[RESOLUTION*i +: RESOLUTION];
      end
      if (drop) overrun <= 1'b1;
      if (state_q == STREAM && m_ready) idx_q <= (idx_q == I_LAST) ? '0 : idx_q + IDX_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_correlator_readout.sv
// Directed bench for correlator_readout (MAX_DELAY=4, RESOLUTION=8, INTEG_CYCLES=10); cycle 0 is the first cycle after reset release.
module tb_correlator_readout;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] counts_in = '0;
  logic        corr_clear;
  logic [7:0]  m_data;
  logic [1:0]  m_index;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;
  logic [15:0] frame_count;
  logic        overrun;
`ifdef CORR_READOUT_HEADER_EN
  logic        m_header;
`endif

  always #5 clk = ~clk;

  correlator_readout #(
    .MAX_DELAY(4), .RESOLUTION(8), .INTEG_CYCLES(10), .TIMER_WIDTH(4), .IDX_WIDTH(2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .counts_in(counts_in),
    .corr_clear(corr_clear), .m_data(m_data), .m_index(m_index), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last),
`ifdef CORR_READOUT_HEADER_EN
    .m_header(m_header),
`endif
    .frame_count(frame_count), .overrun(overrun)
  );

  // -1: no beat, -2: header beat, 0..3: lag beat
  int          expb [32];
  logic [31:0] en_mask, rdy_mask, clr_mask;
  int          fc_from, ov_from, good_until;
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] good = 32'h44332211;
  logic [31:0] junk = 32'hDDCCBBAA;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic clear_tables();
    foreach (expb[i]) expb[i] = -1;
    en_mask = '1; rdy_mask = '1; clr_mask = '0;
    fc_from = 10; ov_from = 99; good_until = 9;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, " clr"}, corr_clear, 0);
    check_eq({tag, " vld"}, m_valid, 0);
    check_eq({tag, " idx"}, m_index, 0);
    check_eq({tag, " dat"}, m_data, 0);
    check_eq({tag, " last"}, m_last, 0);
    check_eq({tag, " fc"}, frame_count, 0);
    check_eq({tag, " ov"}, overrun, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0; enable = 1'b0; m_ready = 1'b0; counts_in = '0;
    #1;
    check_idle_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic run_case(input string name, input int ncyc);
    int          b;
    logic [31:0] lag;
    for (int c = 0; c < ncyc; c++) begin
      enable    = en_mask[c];
      m_ready   = rdy_mask[c];
      counts_in = (c <= good_until) ? good : junk;
      @(negedge clk);
      b = expb[c];
      lag = (b >= 0) ? ((good >> (8 * b)) & 32'hFF) : 32'h01;
      check_eq($sformatf("%s c%0d clr", name, c), corr_clear, clr_mask[c]);
      check_eq($sformatf("%s c%0d vld", name, c), m_valid, b != -1);
      check_eq($sformatf("%s c%0d idx", name, c), m_index, (b >= 0) ? b : 0);
      if (b != -1) check_eq($sformatf("%s c%0d dat", name, c), m_data, lag);
      check_eq($sformatf("%s c%0d last", name, c), m_last, b == 3);
      check_eq($sformatf("%s c%0d fc", name, c), frame_count, (c >= fc_from) ? 1 : 0);
      check_eq($sformatf("%s c%0d ov", name, c), overrun, c >= ov_from);
`ifdef CORR_READOUT_HEADER_EN
      check_eq($sformatf("%s c%0d hdr", name, c), m_header, b == -2);
`endif
      @(posedge clk); #1;
    end
  endtask

  task automatic setup_basic();
    clear_tables();
    clr_mask[10] = 1'b1;
`ifdef CORR_READOUT_HEADER_EN
    expb[10] = -2;
    for (int k = 0; k < 4; k++) expb[11 + k] = k;
`else
    for (int k = 0; k < 4; k++) expb[10 + k] = k;
`endif
  endtask

  initial begin
    // basic frame
    do_reset();
    setup_basic();
    run_case("basic", 15);

    // backpressure on cycles 11-13
    do_reset();
    clear_tables();
    clr_mask[10] = 1'b1;
    rdy_mask[13:11] = 3'b000;
`ifdef CORR_READOUT_HEADER_EN
    expb[10] = -2;
    for (int c = 11; c <= 14; c++) expb[c] = 0;
    expb[15] = 1; expb[16] = 2; expb[17] = 3;
`else
    expb[10] = 0;
    for (int c = 11; c <= 14; c++) expb[c] = 1;
    expb[15] = 2; expb[16] = 3;
`endif
    run_case("bp", 18);

    // overrun: consumer stalled 10..25, windows end at 19 and 29
    do_reset();
    clear_tables();
    clr_mask[10] = 1'b1; clr_mask[20] = 1'b1; clr_mask[30] = 1'b1;
    rdy_mask[25:10] = 16'h0000;
    ov_from = 20;
`ifdef CORR_READOUT_HEADER_EN
    for (int c = 10; c <= 26; c++) expb[c] = -2;
    for (int k = 0; k < 4; k++) expb[27 + k] = k;
`else
    for (int c = 10; c <= 26; c++) expb[c] = 0;
    expb[27] = 1; expb[28] = 2; expb[29] = 3;
`endif
    run_case("ovr", 32);

    // enable low on cycles 3-7 pushes window end to cycle 14
    do_reset();
    clear_tables();
    en_mask[7:3] = 5'b00000;
    clr_mask[15] = 1'b1;
    fc_from = 15; good_until = 14;
`ifdef CORR_READOUT_HEADER_EN
    expb[15] = -2;
    for (int k = 0; k < 4; k++) expb[16 + k] = k;
`else
    for (int k = 0; k < 4; k++) expb[15 + k] = k;
`endif
    run_case("pause", 21);

    // asynchronous reset in the middle of a frame
    do_reset();
    setup_basic();
    run_case("pre", 12);
    check_eq("arst pre vld", m_valid, 1);
    check_eq("arst pre fc", frame_count, 1);
    reset = 1'b0;
    #1;
    check_idle_outputs("arst");
    do_reset();
    setup_basic();
    run_case("post", 15);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
